// File: rtl/rcvbuf_bitstore_if.sv
// rcvbuf_bitstore_if: receive-buffer bus interface.
// Groups the RX-word input side, the playout strobe and the status/serial outputs of
// rcvbuf_bitstore. Clock and reset stay plain ports on the module.
//   newdata  : async rising edge = new word valid on rbr
//   rbr      : RX holding register (DATA_W bits)
//   bit_tick : one-cycle playout strobe
//   databit  : registered serial playout bit
//   ack      : one-cycle pulse when a word is captured
//   rfd      : ready for data
//   rx_full  : store full, playout active
//   rx_empty : one-cycle pulse when the last bit has been played out
//   level    : bits currently held
//   overrun  : sticky dropped-word flag (only with RCVBUF_OVERRUN_EN defined)
// Modports: master = word source / playout consumer, slave = the buffer.
interface rcvbuf_bitstore_if #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned DEPTH_BITS = 10000
);
    localparam int unsigned LVL_W = $clog2(DEPTH_BITS + 1);

    logic              newdata;
    logic [DATA_W-1:0] rbr;
    logic              bit_tick;
    logic              databit;
    logic              ack;
    logic              rfd;
    logic              rx_full;
    logic              rx_empty;
    logic [LVL_W-1:0]  level;
`ifdef RCVBUF_OVERRUN_EN
    logic              overrun;

    modport master (
        output newdata, rbr, bit_tick,
        input  databit, ack, rfd, rx_full, rx_empty, level, overrun
    );
    modport slave (
        input  newdata, rbr, bit_tick,
        output databit, ack, rfd, rx_full, rx_empty, level, overrun
    );
`else
    modport master (
        output newdata, rbr, bit_tick,
        input  databit, ack, rfd, rx_full, rx_empty, level
    );
    modport slave (
        input  newdata, rbr, bit_tick,
        output databit, ack, rfd, rx_full, rx_empty, level
    );
`endif
endinterface

// File: rtl/rcvbuf_bitstore.sv
// rcvbuf_bitstore: parametrised receive bit store.
// Captures DATA_W-bit words from the RX holding register on a (synchronised) rising edge
// of newdata, packs them bit by bit into a DEPTH_BITS-deep store, and once the store is
// full plays the bits out serially, one per bit_tick strobe.
// Ports:
//   rcvbuf_clk : block clock
//   rst_n      : asynchronous active-low reset
//   bus        : rcvbuf_bitstore_if.slave (newdata, rbr, bit_tick in; databit, ack, rfd,
//                rx_full, rx_empty, level and optionally overrun out)
// Optional feature: define RCVBUF_OVERRUN_EN to add the sticky overrun output.
module rcvbuf_bitstore #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned DEPTH_BITS  = 10000,
    parameter bit          LSB_FIRST   = 1'b1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic             rcvbuf_clk,
    input logic             rst_n,
    rcvbuf_bitstore_if.slave bus
);

    localparam int unsigned LVL_W = $clog2(DEPTH_BITS + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH_BITS);
    localparam int unsigned CNT_W = $clog2(DATA_W);

    localparam logic [PTR_W-1:0] PtrLast = PTR_W'(DEPTH_BITS - 1);
    localparam logic [LVL_W-1:0] LvlFull = LVL_W'(DEPTH_BITS);
    localparam logic [LVL_W-1:0] LvlOne  = LVL_W'(1);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StDrain} state_e;

    // ------------------------------------------------------------------
    // newdata synchroniser and rising-edge detect
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_dly_q;
    logic                   nd_rise;

    always_ff @(posedge rcvbuf_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            sync_dly_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], bus.newdata};
            sync_dly_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign nd_rise = sync_q[SYNC_STAGES-1] & ~sync_dly_q;

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    state_e            state_q, state_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              databit_q, databit_d;
    logic              ack_q, ack_d;
    logic              rfd_q, rfd_d;
    logic              rx_full_q, rx_full_d;
    logic              rx_empty_q, rx_empty_d;
`ifdef RCVBUF_OVERRUN_EN
    logic              overrun_q, overrun_d;
`endif

    // Store contents are deliberately left out of reset.
    logic [DEPTH_BITS-1:0] store_q;
    logic                  store_we;
    logic                  store_wbit;
    logic                  last_tick;

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        level_d    = level_q;
        databit_d  = databit_q;
        ack_d      = 1'b0;
        rfd_d      = rfd_q;
        rx_full_d  = rx_full_q;
        rx_empty_d = 1'b0;
        store_we   = 1'b0;
        store_wbit = LSB_FIRST ? word_q[cnt_q] : word_q[CntLast - cnt_q];
        last_tick  = 1'b0;

        // A tick outside DRAIN drives the line low; DRAIN overrides below.
        if (bus.bit_tick) begin
            databit_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (nd_rise) begin
                    word_d  = bus.rbr;
                    ack_d   = 1'b1;
                    rfd_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                store_we = 1'b1;
                wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PTR_W'(1);
                level_d  = level_q + LVL_W'(1);
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CntLast) begin
                    cnt_d = '0;
                    if (level_d == LvlFull) begin
                        rx_full_d = 1'b1;
                        state_d   = StDrain;
                    end else begin
                        rfd_d   = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StDrain: begin
                if (bus.bit_tick) begin
                    databit_d = store_q[rd_ptr_q];
                    rd_ptr_d  = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PTR_W'(1);
                    level_d   = level_q - LVL_W'(1);
                    if (level_q == LvlOne) begin
                        last_tick  = 1'b1;
                        rx_empty_d = 1'b1;
                        rx_full_d  = 1'b0;
                        rfd_d      = 1'b1;
                        wr_ptr_d   = '0;
                        rd_ptr_d   = '0;
                        state_d    = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

`ifdef RCVBUF_OVERRUN_EN
        // Clearing on the final tick wins over a simultaneous dropped edge.
        overrun_d = overrun_q;
        if (last_tick) begin
            overrun_d = 1'b0;
        end else if (nd_rise && !rfd_q) begin
            overrun_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge rcvbuf_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            word_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            level_q    <= '0;
            databit_q  <= 1'b0;
            ack_q      <= 1'b0;
            rfd_q      <= 1'b1;
            rx_full_q  <= 1'b0;
            rx_empty_q <= 1'b0;
`ifdef RCVBUF_OVERRUN_EN
            overrun_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            level_q    <= level_d;
            databit_q  <= databit_d;
            ack_q      <= ack_d;
            rfd_q      <= rfd_d;
            rx_full_q  <= rx_full_d;
            rx_empty_q <= rx_empty_d;
`ifdef RCVBUF_OVERRUN_EN
            overrun_q  <= overrun_d;
`endif
        end
    end

    always_ff @(posedge rcvbuf_clk) begin
        if (store_we) begin
            store_q[wr_ptr_q] <= store_wbit;
        end
    end

    assign bus.databit  = databit_q;
    assign bus.ack      = ack_q;
    assign bus.rfd      = rfd_q;
    assign bus.rx_full  = rx_full_q;
    assign bus.rx_empty = rx_empty_q;
    assign bus.level    = level_q;
`ifdef RCVBUF_OVERRUN_EN
    assign bus.overrun  = overrun_q;
`endif

endmodule
